fetch_ctrl: RTL

Multicycle fetch sequencer between the PC register and the instruction memory port.
- Issues one instruction-memory request at a time for the current PC.
- Captures the returned instruction and holds it for the decode stage while the pipeline is stalled.
- Pulses a PC-advance enable once decode consumes the instruction.
- Discards in-flight responses on a branch-misprediction flush and flags memory timeouts.

---
 rtl/fetch_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multicycle fetch sequencer between the PC register and the
// instruction memory port. One outstanding request at a time; the fetched
// instruction is held for decode until it is consumed or flushed.
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   pc_i                         current PC from the PC register
//   stall_i                      decode cannot accept the presented instruction
//   flush_i                      misprediction flush (PC reloads on this edge)
//   imem_req_o, imem_addr_o      request valid / address to instruction memory
//   imem_gnt_i                   memory accepts the request this cycle
//   imem_rvalid_i, imem_rdata_i  response valid / instruction
//   instr_o, instr_valid_o       instruction presented to decode
//   pc_advance_o                 one-cycle enable for the PC register to step
//   timeout_o                    sticky: a memory response timed out
module fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        pc_advance_o,
    output logic        timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            tmo_q, tmo_d;

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem_gnt_i) begin
                    cnt_d   = '0;
                    // A flush on the grant edge makes the response stale.
                    state_d = flush_i ? StDrop : StWait;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    cnt_d = '0;
                    if (flush_i) begin
                        state_d = StReq;
                    end else begin
                        instr_d = imem_rdata_i;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end else if (flush_i) begin
                    // Flush wins over a coinciding timeout; DROP restarts the count.
                    cnt_d   = '0;
                    state_d = StDrop;
                end else if (cnt_inc == CntMax) begin
                    tmo_d   = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDrop: begin
                if (imem_rvalid_i) begin
                    cnt_d   = '0;
                    state_d = StReq;
                end else if (cnt_inc == CntMax) begin
                    tmo_d   = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                if (flush_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StReq;
                end else if (!stall_i) begin
                    // Consumed: instr_o keeps its last value, only valid drops.
                    valid_d = 1'b0;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req_o   = (state_q == StReq);
        imem_addr_o  = (state_q == StReq) ? pc_i : 32'h0;
        pc_advance_o = (state_q == StHold) && !stall_i && !flush_i;
        instr_o       = instr_q;
        instr_valid_o = valid_q;
        timeout_o     = tmo_q;
    end

endmodule
